sr_cmd_sequencer: RTL

SR_CMD_SEQUENCER -- requirements
Module: sr_cmd_sequencer

---
 rtl/sr_cmd_sequencer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/sr_cmd_sequencer.sv
// sr_cmd_sequencer
// Sequences set/clear commands onto a downstream SR flip-flop: drives s or r
// for HOLD_CYCLES cycles, then watches the flip-flop feedback until it
// matches the command (done pulse) or TIMEOUT check cycles elapse (err pulse).
// Every output is a flop, decoded from the next-state values so it lines up
// with the state it describes in the same cycle.
//
// Legal parameter ranges: HOLD_CYCLES 1..15, TIMEOUT 1..255.

module sr_cmd_sequencer #(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned TIMEOUT     = 8
) (
    input  logic       clk,
    input  logic       rst,        // asynchronous, active-low
    input  logic       cmd_valid,
    input  logic       cmd,        // 1 = set, 0 = clear
    output logic       cmd_ready,
    input  logic       fb,         // feedback from the downstream flip-flop
    output logic       s,
    output logic       r,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] err_cnt
);

    // ------------------------------------------------------------------
    // Types and constants
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

    // Hold counter counts down from HOLD_CYCLES-1 to 0 inclusive, so the
    // drive phase lasts exactly HOLD_CYCLES cycles.
    localparam logic [3:0] HOLD_LOAD    = 4'(HOLD_CYCLES - 1);
    // Timeout counter holds the number of CHECK cycles already spent; the
    // TIMEOUT-th unmatched sample is the one taken when it equals TIMEOUT-1.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] ERR_CNT_MAX  = 8'hFF;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_e     state_q,     state_d;
    logic       cmd_q,       cmd_d;
    logic [3:0] hold_q,      hold_d;
    logic [7:0] tcnt_q,      tcnt_d;
    logic [7:0] err_cnt_q,   err_cnt_d;
    logic       s_q,         s_d;
    logic       r_q,         r_d;
    logic       busy_q,      busy_d;
    logic       cmd_ready_q, cmd_ready_d;
    logic       done_q,      done_d;
    logic       err_q,       err_d;

    logic       handshake;
    logic       fb_match;
    logic       hold_expired;
    logic       timed_out;

    // ------------------------------------------------------------------
    // Condition decode shared by the next-state logic
    // ------------------------------------------------------------------
    // cmd_ready_q is low during reset and for the first cycle after release,
    // so a held cmd_valid is not taken until the block has settled in IDLE.
    assign handshake    = cmd_valid && cmd_ready_q;
    assign fb_match     = (fb == cmd_q);
    assign hold_expired = (hold_q == 4'd0);
    assign timed_out    = (tcnt_q == TIMEOUT_LAST);

    // Next-state, counter and pulse logic for the IDLE/DRIVE/CHECK sequencer
    always_comb begin
        // NOTE: every variable gets a default before the case statement so
        // no path leaves one unassigned, which would infer a latch.
        state_d   = state_q;
        cmd_d     = cmd_q;
        hold_d    = hold_q;
        tcnt_d    = tcnt_q;
        err_cnt_d = err_cnt_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    cmd_d   = cmd;
                    hold_d  = HOLD_LOAD;
                    state_d = ST_DRIVE;
                end
            end

            ST_DRIVE: begin
                // The drive phase always runs to completion, even when the
                // feedback already matches the command.
                if (hold_expired) begin
                    tcnt_d  = 8'd0;
                    state_d = ST_CHECK;
                end else begin
                    hold_d  = hold_q - 4'd1;
                end
            end

            ST_CHECK: begin
                // A match on the final permitted sample still wins over the
                // timeout, so done and err can never fire together.
                if (fb_match) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                    if (err_cnt_q != ERR_CNT_MAX) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end else begin
                    tcnt_d  = tcnt_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state, so the registered outputs always
    // describe the state the FSM is in during the same cycle
    always_comb begin
        s_d         = (state_d == ST_DRIVE) &&  cmd_d;
        r_d         = (state_d == ST_DRIVE) && !cmd_d;
        busy_d      = (state_d != ST_IDLE);
        cmd_ready_d = (state_d == ST_IDLE);
    end

    // State register and counters; reset aborts any command in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cmd_q     <= 1'b0;
            hold_q    <= 4'd0;
            tcnt_q    <= 8'd0;
            err_cnt_q <= 8'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values, independent of statement order.
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            hold_q    <= hold_d;
            tcnt_q    <= tcnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Registered outputs; all drop to their inactive level immediately on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q         <= 1'b0;
            r_q         <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            s_q         <= s_d;
            r_q         <= r_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Port mapping
    // ------------------------------------------------------------------
    assign s         = s_q;
    assign r         = r_q;
    assign busy      = busy_q;
    assign cmd_ready = cmd_ready_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

    // ------------------------------------------------------------------
    // Invariants of the drive and completion outputs
    // ------------------------------------------------------------------
    // The downstream SR flip-flop must never see set and reset together.
    a_sr_exclusive: assert property (@(posedge clk) !(s_q && r_q));

    // A command completes one way only.
    a_done_err_exclusive: assert property (@(posedge clk) disable iff (!rst)
        !(done_q && err_q));

    // Completion pulses last a single cycle.
    a_done_single: assert property (@(posedge clk) disable iff (!rst)
        done_q |=> !done_q);
    a_err_single: assert property (@(posedge clk) disable iff (!rst)
        err_q |=> !err_q);

endmodule
